// File: rtl/vec_length_unit.sv
// vec_length_unit: feeds squared lengths of Q18.14 vectors into an external
// fixed-latency sqrt pipeline, keeps the request metadata aligned with the sqrt
// latency, and queues the results in a tagged first-word-fall-through FIFO.
// Input credit counts FIFO entries plus requests still inside the sqrt
// pipeline, so a result leaving the pipeline always finds a free FIFO slot.
module vec_length_unit #(
    parameter int SQRT_LATENCY = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int TAG_WIDTH    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_x,
    input  logic [31:0]          in_y,
    input  logic [31:0]          in_z,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic [31:0]          sqrt_in,
    input  logic [31:0]          sqrt_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_length,
    output logic [31:0]          out_length_sq,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TOT_W = CNT_W + 1;
    localparam logic signed [65:0] SAT_LIMIT = 66'sh7FFF_FFFF;

    // Metadata travelling alongside a request while the sqrt pipeline works on it.
    typedef struct packed {
        logic                 overflow;
        logic [TAG_WIDTH-1:0] tag;
        logic [31:0]          length_sq;
    } meta_t;

    // One FIFO entry: metadata plus the captured sqrt result.
    typedef struct packed {
        logic                 overflow;
        logic [TAG_WIDTH-1:0] tag;
        logic [31:0]          length_sq;
        logic [31:0]          length;
    } entry_t;

    logic signed [63:0] ext_x, ext_y, ext_z;
    logic signed [63:0] sq_x, sq_y, sq_z;
    logic signed [65:0] sum_sq;
    meta_t              in_meta;

    logic               stage_valid;
    meta_t              stage_meta;
    logic [SQRT_LATENCY-1:0] pipe_valid;
    meta_t              pipe_meta [SQRT_LATENCY];

    entry_t             mem [FIFO_DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_count, inflight_count;
    logic [CNT_W-1:0]   fifo_count_next, inflight_count_next;
    logic [TOT_W-1:0]   total_next;

    logic accept, push, pop;

    assign accept = in_valid && in_ready;
    assign push   = pipe_valid[SQRT_LATENCY-1];
    assign pop    = out_valid && out_ready;

    // Squared length with saturation to the largest positive Q18.14 value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        in_meta  = '0;
        ext_x    = 64'(signed'(in_x));
        ext_y    = 64'(signed'(in_y));
        ext_z    = 64'(signed'(in_z));
        sq_x     = (ext_x * ext_x) >>> 14;
        sq_y     = (ext_y * ext_y) >>> 14;
        sq_z     = (ext_z * ext_z) >>> 14;
        sum_sq   = 66'(sq_x) + 66'(sq_y) + 66'(sq_z);
        in_meta.tag = in_tag;
        if (sum_sq > SAT_LIMIT) begin
            in_meta.length_sq = 32'h7FFF_FFFF;
            in_meta.overflow  = 1'b1;
        end else begin
            in_meta.length_sq = sum_sq[31:0];
            in_meta.overflow  = 1'b0;
        end
    end

    // Next occupancy of the FIFO and of the sqrt pipeline, and the credit total.
    always_comb begin
        fifo_count_next     = fifo_count + CNT_W'(push) - CNT_W'(pop);
        inflight_count_next = inflight_count + CNT_W'(accept) - CNT_W'(push);
        total_next          = TOT_W'(fifo_count_next) + TOT_W'(inflight_count_next);
    end

    // Request stage, metadata delay line, counters and FIFO pointers.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            in_ready       <= 1'b0;
            stage_valid    <= 1'b0;
            stage_meta     <= '0;
            pipe_valid     <= '0;
            for (int i = 0; i < SQRT_LATENCY; i++) pipe_meta[i] <= '0;
            fifo_count     <= '0;
            inflight_count <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
        end else begin
            in_ready    <= total_next < TOT_W'(FIFO_DEPTH);
            stage_valid <= accept;
            if (accept) stage_meta <= in_meta;
            pipe_valid[0] <= stage_valid;
            pipe_meta[0]  <= stage_meta;
            for (int i = 1; i < SQRT_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_meta[i]  <= pipe_meta[i-1];
            end
            fifo_count     <= fifo_count_next;
            inflight_count <= inflight_count_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage: capture the sqrt result together with its aligned metadata.
    always_ff @(posedge clock) begin
        // NOTE: storage is not reset; reads are masked by out_valid, so stale contents are never visible.
        if (push && !reset) begin
            mem[wr_ptr] <= '{overflow:  pipe_meta[SQRT_LATENCY-1].overflow,
                             tag:       pipe_meta[SQRT_LATENCY-1].tag,
                             length_sq: pipe_meta[SQRT_LATENCY-1].length_sq,
                             length:    sqrt_result};
        end
    end

    assign sqrt_in       = stage_meta.length_sq;
    assign head          = mem[rd_ptr];
    assign out_valid     = fifo_count != '0;
    assign out_length    = out_valid ? head.length    : '0;
    assign out_length_sq = out_valid ? head.length_sq : '0;
    assign out_tag       = out_valid ? head.tag       : '0;
    assign out_overflow  = out_valid && head.overflow;

endmodule

// File: tb/tb_vec_length_unit.sv
// Testbench for vec_length_unit: models the external sqrt pipeline, predicts
// each output from the vector arithmetic, and walks through directed and
// randomized scenarios.
module tb_vec_length_unit;

    localparam int L  = 4;
    localparam int D  = 8;
    localparam int TW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_x = '0, in_y = '0, in_z = '0;
    logic [TW-1:0] in_tag = '0;
    logic [31:0]   sqrt_in, sqrt_result;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_length, out_length_sq;
    logic [TW-1:0] out_tag;
    logic          out_overflow;

    vec_length_unit #(.SQRT_LATENCY(L), .FIFO_DEPTH(D), .TAG_WIDTH(TW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag),
        .sqrt_in(sqrt_in), .sqrt_result(sqrt_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_length(out_length), .out_length_sq(out_length_sq),
        .out_tag(out_tag), .out_overflow(out_overflow)
    );

    always #5 clock = ~clock;

    // Integer square root of a Q18.14 value, returned in Q18.14.
    function automatic logic [31:0] q14_sqrt(logic [31:0] v);
        longint unsigned target = longint'(v) << 14;
        longint unsigned r = 0;
        for (int b = 31; b >= 0; b--) begin
            longint unsigned t = r | (64'd1 << b);
            if (t * t <= target) r = t;
        end
        return r[31:0];
    endfunction

    // External sqrt pipeline: free-running, L registered stages.
    logic [31:0] sq_pipe [L] = '{default: '0};
    always @(posedge clock) begin
        sq_pipe[0] <= q14_sqrt(sqrt_in);
        for (int i = 1; i < L; i++) sq_pipe[i] <= sq_pipe[i-1];
    end
    assign sqrt_result = sq_pipe[L-1];

    typedef struct {
        longint        lsq;
        bit            ovf;
        logic [TW-1:0] tag;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0, failed = 0;
    int cyc = 0, pops = 0, first_pop_cyc = -1, last_pop_cyc = -1;
    bit last_acc;

    task automatic check(string name, logic [63:0] obs, logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
        end
    endtask

    task automatic check_len(string name, logic [31:0] obs, longint lsq);
        real r = $sqrt(real'(lsq) * 16384.0);
        real d = real'(obs) - r;
        if (d < 0.0) d = -d;
        tests++;
        assert (d <= r * 0.005 + 1.0) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected~0x%0h", name, obs, longint'(r));
        end
    endtask

    // Reference: the squared length of the vector from plain integer arithmetic.
    function automatic exp_t model(logic [31:0] x, logic [31:0] y, logic [31:0] z, logic [TW-1:0] tag);
        exp_t e;
        longint sx = longint'(signed'(x));
        longint sy = longint'(signed'(y));
        longint sz = longint'(signed'(z));
        longint s  = ((sx * sx) >>> 14) + ((sy * sy) >>> 14) + ((sz * sz) >>> 14);
        e.ovf = s > 64'sh7FFF_FFFF;
        e.lsq = e.ovf ? 64'sh7FFF_FFFF : s;
        e.tag = tag;
        return e;
    endfunction

    // One clock: score any pop against the model, record any accept, advance.
    task automatic tick();
        exp_t e;
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("pop_without_request", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("pop_tag", 64'(out_tag), 64'(e.tag));
                check("pop_length_sq", 64'(out_length_sq), 64'(e.lsq));
                check("pop_overflow", 64'(out_overflow), 64'(e.ovf));
                check_len("pop_length", out_length, e.lsq);
            end
        end
        if (last_acc) exp_q.push_back(model(in_x, in_y, in_z, in_tag));
        if (reset) exp_q.delete();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic set_vec(logic [31:0] x, logic [31:0] y, logic [31:0] z, logic [TW-1:0] tag);
        in_x = x; in_y = y; in_z = z; in_tag = tag;
    endtask

    task automatic send(logic [31:0] x, logic [31:0] y, logic [31:0] z, logic [TW-1:0] tag);
        set_vec(x, y, z, tag);
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (last_acc) break;
        end
        check("send_accepted", 64'(last_acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_head(string name);
        for (int i = 0; i < 64; i++) begin
            if (out_valid) break;
            tick();
        end
        check(name, 64'(out_valid), 64'd1);
    endtask

    task automatic expect_head(string name, logic [31:0] lsq, logic ovf);
        wait_head({name, "_valid"});
        check({name, "_length_sq"}, 64'(out_length_sq), 64'(lsq));
        check({name, "_overflow"}, 64'(out_overflow), 64'(ovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rnd_comp();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 32'h7FFFF)) - 32'h40000;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, p0, start, bubbles, sent;

        // Reset state
        #1;
        tick(); tick();
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_sqrt_in", 64'(sqrt_in), 64'd0);
        check("reset_out_data", {out_length, out_length_sq}, 64'd0);
        reset = 1'b0;
        tick();
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        // (1) Unit vector along x, latency and data
        set_vec(32'h4000, 0, 0, 8'h11);
        in_valid = 1'b1;
        check("t1_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("t1_sqrt_in", 64'(sqrt_in), 64'h4000);
        for (int k = 1; k <= 5; k++) begin
            check("t1_early_valid", 64'(out_valid), 64'd0);
            tick();
        end
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_tag", 64'(out_tag), 64'h11);
        check("t1_length_sq", 64'(out_length_sq), 64'h4000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // (2) 3-4-5 triangle, both signs
        send(32'h0000C000, 32'h00010000, 0, 8'h21);
        send(-32'sh0000C000, -32'sh00010000, 0, 8'h22);
        expect_head("t2_pos", 32'h64000, 1'b0);
        expect_head("t2_neg", 32'h64000, 1'b0);

        // (3) Backpressure: credit limit then drain in order
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid = idx < 10;
            set_vec(rnd_comp(), rnd_comp(), 0, 8'(8'h30 + idx));
            tick();
            if (last_acc) idx++;
        end
        in_valid = 1'b0;
        check("t3_accepted", 64'(idx), 64'd8);
        check("t3_ready_low", 64'(in_ready), 64'd0);
        wait_head("t3_head_valid");
        check("t3_head_tag", 64'(out_tag), 64'h30);
        for (int c = 0; c < 8; c++) tick();
        check("t3_head_hold", 64'(out_tag), 64'h30);
        check("t3_ready_still_low", 64'(in_ready), 64'd0);
        p0 = pops;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && pops - p0 < 8; c++) tick();
        out_ready = 1'b0;
        check("t3_drained", 64'(pops - p0), 64'd8);
        tick();
        check("t3_ready_back", 64'(in_ready), 64'd1);
        check("t3_empty", 64'(out_valid), 64'd0);

        // (4) Saturation and recovery
        send(32'h7FFFFFFF, 0, 0, 8'h41);
        send(32'h80000000, 0, 0, 8'h42);
        send(32'h4000, 0, 0, 8'h43);
        expect_head("t4_max", 32'h7FFFFFFF, 1'b1);
        expect_head("t4_min", 32'h7FFFFFFF, 1'b1);
        expect_head("t4_after", 32'h4000, 1'b0);

        // (5) Full throughput with random vectors
        out_ready = 1'b1;
        sent = 0; bubbles = 0; p0 = pops;
        first_pop_cyc = -1;
        start = cyc;
        for (int c = 0; c < 80 && pops - p0 < 20; c++) begin
            if (sent < 20) begin
                in_valid = 1'b1;
                set_vec(rnd_comp(), rnd_comp(), rnd_comp(), 8'(sent));
                if (!in_ready) bubbles++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (last_acc) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("t5_outputs", 64'(pops - p0), 64'd20);
        check("t5_bubbles", 64'(bubbles), 64'd0);
        check("t5_fill", 64'(first_pop_cyc - start), 64'd6);
        check("t5_rate", 64'(last_pop_cyc - first_pop_cyc), 64'd19);

        // (6) Reset with requests in flight
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_vec(32'h8000, 32'h4000, 0, 8'(8'h60 + c));
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_no_valid_after_reset", 64'(out_valid), 64'd0);
        tick();
        check("t6_ready", 64'(in_ready), 64'd1);
        send(32'h0000C000, 0, 32'h00010000, 8'h77);
        for (int c = 0; c < 5; c++) begin
            check("t6_quiet", 64'(out_valid), 64'd0);
            tick();
        end
        check("t6_tag", 64'(out_tag), 64'h77);
        expect_head("t6_new", 32'h64000, 1'b0);
        for (int c = 0; c < 6; c++) tick();
        check("t6_alone", 64'(out_valid), 64'd0);

        // (7) Zero vector
        send(0, 0, 0, 8'h70);
        wait_head("t7_valid");
        check("t7_length", 64'(out_length), 64'd0);
        expect_head("t7", 32'h0, 1'b0);
        check("model_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
